// File: rtl/skintone_div_pkg.sv
// Shared types and constants for the skin-tone mean divider-sharing block.
package skintone_div_pkg;

  localparam int DATA_W = 16;
  localparam int QUOT_W = 16;
  localparam int FRAC_W = 8;

  localparam logic REQ_CB = 1'b0;
  localparam logic REQ_CR = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
    logic div0;
  } div_tag_t;

  typedef struct packed {
    logic [QUOT_W-1:0] quotient;
    logic [FRAC_W-1:0] fraction;
    logic              div0;
  } div_res_t;

  function automatic logic is_zero(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/div_res_fifo.sv
// Single-clock result FIFO (depth DEPTH, power of 2) holding div_res_t entries.
module div_res_fifo
  import skintone_div_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  div_res_t i_data,
  output logic     o_valid,
  input  logic     i_pop,
  output div_res_t o_data
);

  localparam int AW = $clog2(DEPTH);

  div_res_t       r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  always_comb begin
    w_pop  = i_pop && (r_count != '0);
    w_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);
  end

  // Storage array, data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/div_share_arb.sv
// Round-robin sharing of one pipelined divider between mean_cb (0) and mean_cr (1).
// Optional macro DIV_SHARE_ZERO_GUARD_EN substitutes zero divisors and flags div0.
module div_share_arb
  import skintone_div_pkg::*;
#(
  parameter int DIV_LATENCY = 20,
  parameter int RES_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_dividend,
  input  logic [DATA_W-1:0] req0_divisor,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_dividend,
  input  logic [DATA_W-1:0] req1_divisor,
  input  logic              div_rfd,
  output logic              div_issue,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic [QUOT_W-1:0] div_quotient,
  input  logic [FRAC_W-1:0] div_fractional,
  output logic              res0_valid,
  input  logic              res0_ready,
  output logic [QUOT_W-1:0] res0_quotient,
  output logic [FRAC_W-1:0] res0_fractional,
  output logic              res0_div0,
  output logic              res1_valid,
  input  logic              res1_ready,
  output logic [QUOT_W-1:0] res1_quotient,
  output logic [FRAC_W-1:0] res1_fractional,
  output logic              res1_div0,
  output logic              busy
);

  localparam int CW = $clog2(RES_DEPTH + 1);

  logic [CW-1:0]     r_credit0;
  logic [CW-1:0]     r_credit1;
  logic              r_last_grant;
  logic              r_div_issue;
  logic [DATA_W-1:0] r_div_dividend;
  logic [DATA_W-1:0] r_div_divisor;
  logic              r_issue_id;
  logic              r_issue_div0;
  div_tag_t          r_tag [DIV_LATENCY];

  logic              w_elig0;
  logic              w_elig1;
  logic              w_grant0;
  logic              w_grant1;
  logic [DATA_W-1:0] w_sel_dividend;
  logic [DATA_W-1:0] w_sel_divisor;
  logic [DATA_W-1:0] w_iss_dividend;
  logic [DATA_W-1:0] w_iss_divisor;
  logic              w_zero;
  div_tag_t          w_exit;
  div_res_t          w_cap;
  logic              w_push0;
  logic              w_push1;
  logic              w_pop0;
  logic              w_pop1;
  logic              w_valid0;
  logic              w_valid1;
  div_res_t          w_res0;
  div_res_t          w_res1;
  logic              w_busy;

  // Credit = free result-buffer slots not yet reserved by an in-flight issue.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] c, input logic g,
                                                input logic p);
    logic [CW-1:0] n;
    case ({g, p})
      2'b10:   n = (c == '0) ? c : c - CW'(1);
      2'b01:   n = (c == CW'(RES_DEPTH)) ? c : c + CW'(1);
      default: n = c;
    endcase
    return n;
  endfunction

  always_comb begin
    w_elig0  = req0_valid && (r_credit0 != '0) && div_rfd && !rst;
    w_elig1  = req1_valid && (r_credit1 != '0) && div_rfd && !rst;
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_elig0 && w_elig1) begin
      // On contention the requester not granted last wins.
      if (r_last_grant == REQ_CB) w_grant1 = 1'b1;
      else                        w_grant0 = 1'b1;
    end else begin
      w_grant0 = w_elig0;
      w_grant1 = w_elig1;
    end
  end

  always_comb begin
    w_sel_dividend = w_grant1 ? req1_dividend : req0_dividend;
    w_sel_divisor  = w_grant1 ? req1_divisor  : req0_divisor;
`ifdef DIV_SHARE_ZERO_GUARD_EN
    w_zero         = is_zero(w_sel_divisor);
    w_iss_dividend = w_zero ? {DATA_W{1'b0}} : w_sel_dividend;
    w_iss_divisor  = w_zero ? DATA_W'(1)     : w_sel_divisor;
`else
    w_zero         = 1'b0;
    w_iss_dividend = w_sel_dividend;
    w_iss_divisor  = w_sel_divisor;
`endif
  end

  // Issue register towards the core plus round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_issue    <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_issue_id     <= 1'b0;
      r_issue_div0   <= 1'b0;
      r_last_grant   <= REQ_CB;
    end else begin
      r_div_issue <= w_grant0 || w_grant1;
      if (w_grant0 || w_grant1) begin
        r_div_dividend <= w_iss_dividend;
        r_div_divisor  <= w_iss_divisor;
        r_issue_id     <= w_grant1;
        r_issue_div0   <= w_zero;
        r_last_grant   <= w_grant1;
      end
    end
  end

  // Tag line aligned with the core latency; stage 0 follows the issue cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIV_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: r_div_issue, id: r_issue_id, div0: r_issue_div0};
      for (int i = 1; i < DIV_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_comb begin
    w_exit       = r_tag[DIV_LATENCY-1];
    w_cap        = '0;
    w_cap.div0   = w_exit.div0;
    if (w_exit.div0) begin
      w_cap.quotient = '0;
      w_cap.fraction = '0;
    end else begin
      w_cap.quotient = div_quotient;
      w_cap.fraction = div_fractional;
    end
    w_push0 = w_exit.valid && (w_exit.id == REQ_CB);
    w_push1 = w_exit.valid && (w_exit.id == REQ_CR);
    w_pop0  = w_valid0 && res0_ready;
    w_pop1  = w_valid1 && res1_ready;
  end

  // Credits reserve buffer space at grant time, released on consumer pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit0 <= CW'(RES_DEPTH);
      r_credit1 <= CW'(RES_DEPTH);
    end else begin
      r_credit0 <= credit_next(r_credit0, w_grant0, w_pop0);
      r_credit1 <= credit_next(r_credit1, w_grant1, w_pop1);
    end
  end

  div_res_fifo #(.DEPTH(RES_DEPTH)) u_fifo_cb (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push0),
    .i_data  (w_cap),
    .o_valid (w_valid0),
    .i_pop   (w_pop0),
    .o_data  (w_res0)
  );

  div_res_fifo #(.DEPTH(RES_DEPTH)) u_fifo_cr (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push1),
    .i_data  (w_cap),
    .o_valid (w_valid1),
    .i_pop   (w_pop1),
    .o_data  (w_res1)
  );

  always_comb begin
    w_busy = r_div_issue || w_valid0 || w_valid1;
    for (int i = 0; i < DIV_LATENCY; i++) w_busy = w_busy || r_tag[i].valid;
  end

  assign req0_ready      = w_grant0;
  assign req1_ready      = w_grant1;
  assign div_issue       = r_div_issue;
  assign div_dividend    = r_div_dividend;
  assign div_divisor     = r_div_divisor;
  assign res0_valid      = w_valid0;
  assign res0_quotient   = w_res0.quotient;
  assign res0_fractional = w_res0.fraction;
  assign res0_div0       = w_res0.div0;
  assign res1_valid      = w_valid1;
  assign res1_quotient   = w_res1.quotient;
  assign res1_fractional = w_res1.fraction;
  assign res1_div0       = w_res1.div0;
  assign busy            = w_busy;

endmodule

// File: tb/tb_div_share_arb.sv
// Scoreboard bench for div_share_arb with a 20-cycle pipelined divider model.
module tb_div_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
  logic        div_rfd, div_issue;
  logic [15:0] div_dividend, div_divisor, div_quotient;
  logic [7:0]  div_fractional;
  logic        res0_valid, res0_ready, res0_div0, res1_valid, res1_ready, res1_div0;
  logic [15:0] res0_quotient, res1_quotient;
  logic [7:0]  res0_fractional, res1_fractional;
  logic        busy;

  div_share_arb #(.DIV_LATENCY(20), .RES_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
    .div_rfd(div_rfd), .div_issue(div_issue),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_fractional(div_fractional),
    .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_quotient(res0_quotient),
    .res0_fractional(res0_fractional), .res0_div0(res0_div0),
    .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_quotient(res1_quotient),
    .res1_fractional(res1_fractional), .res1_div0(res1_div0),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider core model: 20-stage pipeline, output aligned 20 cycles after div_issue.
  function automatic logic [15:0] mq(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'd0) return 16'hFFFF;
    return a / b;
  endfunction
  function automatic logic [7:0] mf(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    if (b == 16'd0) return 8'hFF;
    r = (32'(a % b) * 32'd256) / 32'(b);
    return r[7:0];
  endfunction

  logic [15:0] m_q [20];
  logic [7:0]  m_f [20];
  always @(posedge clk) begin
    m_q[0] <= mq(div_dividend, div_divisor);
    m_f[0] <= mf(div_dividend, div_divisor);
    for (int i = 1; i < 20; i++) begin
      m_q[i] <= m_q[i-1];
      m_f[i] <= m_f[i-1];
    end
  end
  assign div_quotient   = m_q[19];
  assign div_fractional = m_f[19];

  typedef struct {
    logic [15:0] q;
    logic [7:0]  f;
    logic        d0;
    int          due;
  } exp_t;
  exp_t exp0[$];
  exp_t exp1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int bp_acc;
  int seen;

  // Hand-computed vectors: a, b, quotient, fraction (fraction = floor(rem*256/b)).
  logic [15:0] cv0_a [4] = '{16'd100, 16'd7,   16'd1000, 16'd255};
  logic [15:0] cv0_b [4] = '{16'd4,   16'd2,   16'd3,    16'd16};
  logic [15:0] cv0_q [4] = '{16'd25,  16'd3,   16'd333,  16'd15};
  logic [7:0]  cv0_f [4] = '{8'd0,    8'd128,  8'd85,    8'd240};
  logic [15:0] cv1_a [4] = '{16'd9,   16'd65535, 16'd10, 16'd1};
  logic [15:0] cv1_b [4] = '{16'd4,   16'd1,     16'd3,  16'd2};
  logic [15:0] cv1_q [4] = '{16'd2,   16'd65535, 16'd3,  16'd0};
  logic [7:0]  cv1_f [4] = '{8'd64,   8'd0,      8'd85,  8'd128};

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_exp(input bit ch, input logic [15:0] q, input logic [7:0] f,
                          input logic d0, input int due);
    exp_t e;
    e.q = q; e.f = f; e.d0 = d0; e.due = due;
    if (ch) exp1.push_back(e);
    else    exp0.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every popped result against the head of its queue.
  task automatic mon_step();
    exp_t e;
    if (!rst && res0_valid && res0_ready) begin
      if (exp0.size() == 0) chk("res0_unexpected", res0_valid, 0);
      else begin
        e = exp0.pop_front();
        chk("res0_quot", res0_quotient, e.q);
        chk("res0_frac", res0_fractional, e.f);
        chk("res0_div0", res0_div0, e.d0);
        if (e.due >= 0) chk("res0_latency", cyc, e.due);
      end
    end
    if (!rst && res1_valid && res1_ready) begin
      if (exp1.size() == 0) chk("res1_unexpected", res1_valid, 0);
      else begin
        e = exp1.pop_front();
        chk("res1_quot", res1_quotient, e.q);
        chk("res1_frac", res1_fractional, e.f);
        chk("res1_div0", res1_div0, e.d0);
        if (e.due >= 0) chk("res1_latency", cyc, e.due);
      end
    end
  endtask

  // Holds one request until accepted; expectation pushed with latency deadline.
  task automatic send(input bit ch, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] q, input logic [7:0] f, input logic d0);
    logic got = 1'b0;
    if (ch) begin req1_valid = 1'b1; req1_dividend = a; req1_divisor = b; end
    else    begin req0_valid = 1'b1; req0_dividend = a; req0_divisor = b; end
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = ch ? req1_ready : req0_ready;
      if (got) push_exp(ch, q, f, d0, cyc + 22);
      tick();
    end
    chk("send_accept", got, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bp_cycle();
    @(negedge clk);
    if (req0_ready) begin
      bp_acc++;
      push_exp(1'b0, 16'd12, 8'd0, 1'b0, -1);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; div_rfd = 1'b1; res0_ready = 1'b1; res1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_dividend = 16'd5; req0_divisor = 16'd1; req1_dividend = 16'd0; req1_divisor = 16'd0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    // Reset state, with a request pending that must not be granted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_issue", div_issue, 0);
    chk("rst_res0_valid", res0_valid, 0);
    chk("rst_res1_valid", res1_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_dividend", div_dividend, 0);
    chk("rst_div_divisor", div_divisor, 0);
    chk("rst_res_div0", int'(res0_div0) + int'(res1_div0), 0);
    req0_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Single request: 100/4, result 22 cycles after accept; res1 stays idle.
    send(1'b0, 16'd100, 16'd4, 16'd25, 8'd0, 1'b0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res1_valid) seen = 1;
      tick();
    end
    chk("single_res1_idle", seen, 0);
    chk("single_drained", exp0.size(), 0);

    // Contention: both valid 8 cycles, grants alternate starting with req1.
    begin
      int k0 = 0, k1 = 0, i0, i1;
      logic exp_id = 1'b1;
      for (int c = 0; c < 8; c++) begin
        i0 = (k0 < 4) ? k0 : 3;
        i1 = (k1 < 4) ? k1 : 3;
        req0_valid = 1'b1; req0_dividend = cv0_a[i0]; req0_divisor = cv0_b[i0];
        req1_valid = 1'b1; req1_dividend = cv1_a[i1]; req1_divisor = cv1_b[i1];
        @(negedge clk);
        chk("cont_onehot", int'(req0_ready) + int'(req1_ready), 1);
        chk("cont_order", req1_ready, exp_id);
        if (req0_ready) begin push_exp(1'b0, cv0_q[i0], cv0_f[i0], 1'b0, cyc + 22); k0++; end
        if (req1_ready) begin push_exp(1'b1, cv1_q[i1], cv1_f[i1], 1'b0, cyc + 22); k1++; end
        exp_id = ~exp_id;
        tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("cont_issues0", k0, 4);
      chk("cont_issues1", k1, 4);
    end
    drain(30);
    chk("cont_drained0", exp0.size(), 0);
    chk("cont_drained1", exp1.size(), 0);

    // Backpressure: consumer stalled, exactly RES_DEPTH accepts, one pop frees one slot.
    res0_ready = 1'b0;
    req0_valid = 1'b1; req0_dividend = 16'd60; req0_divisor = 16'd5;
    bp_acc = 0;
    for (int i = 0; i < 10; i++) bp_cycle();
    chk("bp_accepts", bp_acc, 4);
    @(negedge clk);
    chk("bp_ready_low", req0_ready, 0);
    tick();
    for (int i = 0; i < 40 && !res0_valid; i++) bp_cycle();
    chk("bp_res_valid", res0_valid, 1);
    res0_ready = 1'b1;
    tick();
    res0_ready = 1'b0;
    for (int i = 0; i < 30; i++) bp_cycle();
    chk("bp_accepts_after_pop", bp_acc, 5);
    req0_valid = 1'b0;
    res0_ready = 1'b1;
    drain(40);
    chk("bp_drained", exp0.size(), 0);

    // rfd stall: no grants or issues while div_rfd is low; in-flight stays on time.
    for (int c = 0; c < 12; c++) begin
      div_rfd = !(c >= 4 && c < 9);
      req0_valid = (c < 3); req0_dividend = 16'd200; req0_divisor = 16'd8;
      req1_valid = (c >= 3); req1_dividend = 16'd90; req1_divisor = 16'd9;
      @(negedge clk);
      if (c >= 4 && c < 9) chk("rfd_no_grant", int'(req0_ready) + int'(req1_ready), 0);
      if (c >= 5 && c < 10) chk("rfd_no_issue", div_issue, 0);
      if (req0_ready) push_exp(1'b0, 16'd25, 8'd0, 1'b0, cyc + 22);
      if (req1_ready) push_exp(1'b1, 16'd10, 8'd0, 1'b0, cyc + 22);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; div_rfd = 1'b1;
    drain(30);
    chk("rfd_drained0", exp0.size(), 0);
    chk("rfd_drained1", exp1.size(), 0);

    // Zero divisor on req1.
`ifdef DIV_SHARE_ZERO_GUARD_EN
    send(1'b1, 16'd50, 16'd0, 16'd0, 8'd0, 1'b1);
    @(negedge clk);
    chk("zero_issue", div_issue, 1);
    chk("zero_div_divisor", div_divisor, 1);
    chk("zero_div_dividend", div_dividend, 0);
`else
    send(1'b1, 16'd50, 16'd0, 16'hFFFF, 8'hFF, 1'b0);
    @(negedge clk);
    chk("zero_issue", div_issue, 1);
    chk("zero_div_divisor", div_divisor, 0);
    chk("zero_div_dividend", div_dividend, 50);
`endif
    tick();
    drain(30);
    chk("zero_drained", exp1.size(), 0);

    // Reset with six issues in flight: results discarded, credits restored.
    begin
      int n_acc = 0;
      for (int c = 0; c < 6; c++) begin
        req0_valid = 1'b1; req0_dividend = 16'd33; req0_divisor = 16'd3;
        req1_valid = 1'b1; req1_dividend = 16'd44; req1_divisor = 16'd4;
        @(negedge clk);
        n_acc += int'(req0_ready) + int'(req1_ready);
        tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("rst_mid_accepts", n_acc, 6);
    end
    drain(3);
    @(negedge clk);
    chk("rst_mid_busy_before", busy, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res0_valid || res1_valid) seen = 1;
      if (i == 20) chk("rst_mid_busy_after", busy, 0);
      tick();
    end
    chk("rst_mid_no_results", seen, 0);
    res0_ready = 1'b0;
    req0_valid = 1'b1; req0_dividend = 16'd60; req0_divisor = 16'd5;
    bp_acc = 0;
    for (int i = 0; i < 10; i++) bp_cycle();
    chk("rst_mid_credits", bp_acc, 4);
    req0_valid = 1'b0;
    res0_ready = 1'b1;
    drain(40);
    chk("final_drained0", exp0.size(), 0);
    chk("final_drained1", exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
